seq_window_checker: RTL and testbench

- Synthesizable, parametrised checker for the implication "a, then b within [MIN_DLY:MAX_DLY] cycles |-> c on that same cycle".
- Runs N_CH independent channels with overlapping attempts, optional first-match retirement and optional strong (b-must-occur) semantics.
- Reports per-channel violation pulses, sticky flags and a saturating global violation count.
- Sits beside the DUT in the chapter benches as the hardware counterpart of the SVA violation counter.

---
 rtl/seq_window_checker.sv | 112 +++++++++++
 tb/tb_seq_window_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_window_checker.sv
// seq_window_checker: hardware checker for "a, then b within [MIN_DLY:MAX_DLY] cycles |-> c on that cycle"
//
// Ports:
//   clk        in   sampling clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   a          in   [N_CH]  antecedent start per channel
//   b          in   [N_CH]  sequence end event per channel
//   c          in   [N_CH]  consequent, required high when b completes an in-window attempt
//   clr        in   synchronous clear of err_sticky, err_count (and pass_count)
//   err        out  [N_CH]  one-cycle registered violation pulse per channel
//   err_sticky out  [N_CH]  set with err, held until clr or reset
//   err_count  out  [CNT_W] saturating total of violation events
//   pass_count out  [CNT_W] saturating total of pass events (only with SEQ_CHK_COVER_EN)
//   busy       out  [N_CH]  channel has at least one pending attempt
//
// Optional feature: define SEQ_CHK_COVER_EN to add the pass_count output.
module seq_window_checker #(
    parameter int N_CH        = 4,
    parameter int MIN_DLY     = 2,
    parameter int MAX_DLY     = 3,
    parameter int FIRST_MATCH = 0,
    parameter int STRONG      = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   a,
    input  logic [N_CH-1:0]   b,
    input  logic [N_CH-1:0]   c,
    input  logic              clr,
    output logic [N_CH-1:0]   err,
    output logic [N_CH-1:0]   err_sticky,
    output logic [CNT_W-1:0]  err_count,
`ifdef SEQ_CHK_COVER_EN
    output logic [CNT_W-1:0]  pass_count,
`endif
    output logic [N_CH-1:0]   busy
);
    localparam int PW = $clog2(N_CH + 1);
    localparam int SW = (CNT_W > PW ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // pend[i][k]: channel i saw a exactly k cycles ago.
    // hit[i][k]: the attempt in slot k has already been matched by an in-window b.
    logic [N_CH-1:0][MAX_DLY:1] pend, pend_nxt, hit, hit_nxt;
    logic [N_CH-1:0] win, chk, expire, viol;
    logic [PW-1:0] n_viol;
    logic [SW-1:0] err_sum;
    logic [CNT_W-1:0] err_count_nxt;

    always_comb begin
        n_viol = '0;
        for (int i = 0; i < N_CH; i++) begin
            win[i]    = |pend[i][MAX_DLY:MIN_DLY];
            chk[i]    = win[i] && b[i];
            // Expiry only counts for attempts that were never matched; with
            // first-match retirement a matched attempt never reaches MAX_DLY.
            expire[i] = STRONG != 0 && pend[i][MAX_DLY] && !b[i] &&
                        (FIRST_MATCH != 0 || !hit[i][MAX_DLY]);
            viol[i]   = (chk[i] && !c[i]) || expire[i];
            n_viol    = n_viol + PW'(viol[i]);
            pend_nxt[i][1] = a[i];
            hit_nxt[i][1]  = 1'b0;
            for (int k = 2; k <= MAX_DLY; k++) begin
                pend_nxt[i][k] = pend[i][k-1] && !(FIRST_MATCH != 0 && chk[i] && k > MIN_DLY);
                hit_nxt[i][k]  = hit[i][k-1] || (b[i] && pend[i][k-1] && k > MIN_DLY);
            end
            busy[i] = |pend[i];
        end
        err_sum       = SW'(err_count) + SW'(n_viol);
        err_count_nxt = (err_sum > SW'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            hit        <= '0;
            err        <= '0;
            err_sticky <= '0;
            err_count  <= '0;
        end else begin
            pend       <= pend_nxt;
            hit        <= hit_nxt;
            err        <= viol;
            err_sticky <= clr ? '0 : (err_sticky | viol);
            err_count  <= clr ? '0 : err_count_nxt;
        end
    end

`ifdef SEQ_CHK_COVER_EN
    logic [N_CH-1:0] pass;
    logic [PW-1:0] n_pass;
    logic [SW-1:0] pass_sum;
    logic [CNT_W-1:0] pass_count_nxt;

    always_comb begin
        n_pass = '0;
        for (int i = 0; i < N_CH; i++) begin
            pass[i] = chk[i] && c[i] && !viol[i];
            n_pass  = n_pass + PW'(pass[i]);
        end
        pass_sum       = SW'(pass_count) + SW'(n_pass);
        pass_count_nxt = (pass_sum > SW'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pass_count <= '0;
        else        pass_count <= clr ? '0 : pass_count_nxt;
    end
`endif

endmodule

// File: tb/tb_seq_window_checker.sv
// tb_seq_window_checker: directed bench for seq_window_checker over four parameter sets
module tb_seq_window_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] a = '0, b = '0, c = '0;
    logic clr = 1'b0;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // d: defaults, f: FIRST_MATCH+STRONG, s: STRONG only, t: CNT_W=2
    logic [3:0] err_d, sticky_d, busy_d, err_f, sticky_f, busy_f;
    logic [3:0] err_s, sticky_s, busy_s, err_t, sticky_t, busy_t;
    logic [15:0] cnt_d, cnt_f, cnt_s;
    logic [1:0] cnt_t;
`ifdef SEQ_CHK_COVER_EN
    logic [15:0] pc_d, pc_f, pc_s;
    logic [1:0] pc_t;
`endif

    seq_window_checker u_d (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .clr(clr),
        .err(err_d), .err_sticky(sticky_d), .err_count(cnt_d),
`ifdef SEQ_CHK_COVER_EN
        .pass_count(pc_d),
`endif
        .busy(busy_d));

    seq_window_checker #(.FIRST_MATCH(1), .STRONG(1)) u_f (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .clr(clr),
        .err(err_f), .err_sticky(sticky_f), .err_count(cnt_f),
`ifdef SEQ_CHK_COVER_EN
        .pass_count(pc_f),
`endif
        .busy(busy_f));

    seq_window_checker #(.STRONG(1)) u_s (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .clr(clr),
        .err(err_s), .err_sticky(sticky_s), .err_count(cnt_s),
`ifdef SEQ_CHK_COVER_EN
        .pass_count(pc_s),
`endif
        .busy(busy_s));

    seq_window_checker #(.CNT_W(2)) u_t (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .clr(clr),
        .err(err_t), .err_sticky(sticky_t), .err_count(cnt_t),
`ifdef SEQ_CHK_COVER_EN
        .pass_count(pc_t),
`endif
        .busy(busy_t));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // a at cycle 0, b/c (and clr) at cycle 2; returns at cycle 3
    task automatic attempt(input logic [3:0] am, input logic [3:0] bm, input logic [3:0] cm,
                           input logic cl);
        a = am;
        tick();
        a = '0;
        tick();
        b = bm; c = cm; clr = cl;
        tick();
        b = '0; c = '0; clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        check("rst_err", 32'(err_d), 0);
        check("rst_sticky", 32'(sticky_d), 0);
        check("rst_count", 32'(cnt_d), 0);
        check("rst_busy", 32'(busy_d), 0);

        attempt(4'b0001, 4'b0001, 4'b0001, 1'b0);
        check("pass_err", 32'(err_d), 0);
        check("pass_count", 32'(cnt_d), 0);
        check("pass_err_s", 32'(err_s), 0);
        idle(3);
        check("pass_noexp_f", 32'(cnt_f), 0);
        check("pass_noexp_s", 32'(cnt_s), 0);

        attempt(4'b0001, 4'b0001, 4'b0000, 1'b0);
        check("viol_err", 32'(err_d), 1);
        check("viol_sticky", 32'(sticky_d), 1);
        check("viol_count", 32'(cnt_d), 1);
        tick();
        check("viol_err_pulse", 32'(err_d), 0);
        check("viol_sticky_hold", 32'(sticky_d), 1);
        check("viol_matched_noexp_s", 32'(cnt_s), 1);
        idle(2);

        a = 4'b0010;
        tick();
        a = '0;
        check("busy_c1", 32'(busy_d), 2);
        b = 4'b0010;
        tick();
        b = '0;
        check("busy_c2", 32'(busy_d), 2);
        check("early_b_err", 32'(err_d), 0);
        tick();
        check("busy_c3", 32'(busy_d), 2);
        tick();
        check("busy_c4", 32'(busy_d), 0);
        check("late_expire_f", 32'(err_f), 2);
        check("late_expire_s", 32'(err_s), 2);
        check("late_err_d", 32'(err_d), 0);
        b = 4'b0010;
        tick();
        b = '0;
        check("late_b_err", 32'(err_d), 0);
        check("late_count_d", 32'(cnt_d), 1);
        check("late_count_f", 32'(cnt_f), 2);
        idle(2);

        attempt(4'b0100, 4'b0100, 4'b0100, 1'b0);
        check("fm_first_err", 32'(err_d), 0);
        b = 4'b0100;
        tick();
        b = '0;
        check("fm0_recheck_err", 32'(err_d), 4);
        check("fm1_retired_err", 32'(err_f), 0);
        check("fm0_count", 32'(cnt_d), 2);
        check("fm1_count", 32'(cnt_f), 2);
        idle(3);

        attempt(4'b0100, 4'b0100, 4'b0100, 1'b0);
        tick();
        check("matched_noexp_s", 32'(err_s), 0);
        check("matched_noexp_f", 32'(err_f), 0);
        idle(2);
        check("strong_count_s", 32'(cnt_s), 3);

        attempt(4'b1000, 4'b0000, 4'b0000, 1'b0);
        tick();
        check("strong_exp_f", 32'(err_f), 8);
        check("strong_exp_s", 32'(err_s), 8);
        check("weak_noexp_d", 32'(err_d), 0);
        idle(2);
        check("strong_count_f", 32'(cnt_f), 3);

        attempt(4'b1111, 4'b1111, 4'b0000, 1'b0);
        check("all_err", 32'(err_d), 15);
        check("all_sticky", 32'(sticky_d), 15);
        check("all_count", 32'(cnt_d), 6);
        check("all_sat_t", 32'(cnt_t), 3);
        idle(3);

        attempt(4'b1111, 4'b1111, 4'b0000, 1'b1);
        check("clr_err_kept", 32'(err_d), 15);
        check("clr_count", 32'(cnt_d), 0);
        check("clr_sticky", 32'(sticky_d), 0);
        check("clr_count_t", 32'(cnt_t), 0);
        idle(3);

        attempt(4'b1111, 4'b1111, 4'b0000, 1'b0);
        check("sat4_t", 32'(cnt_t), 3);
        idle(3);
        attempt(4'b0001, 4'b0001, 4'b0000, 1'b0);
        check("sat5_t", 32'(cnt_t), 3);
        check("count5_d", 32'(cnt_d), 5);
        idle(3);

        a = 4'b0001;
        tick();
        a = '0;
        rst_n = 1'b0;
        #1;
        check("async_count", 32'(cnt_d), 0);
        check("async_sticky", 32'(sticky_d), 0);
        check("async_busy", 32'(busy_d), 0);
        tick();
        rst_n = 1'b1;
        b = 4'b0001;
        c = 4'b0000;
        tick();
        b = '0;
        check("post_rst_err", 32'(err_d), 0);
        check("post_rst_count", 32'(cnt_d), 0);
        check("post_rst_busy", 32'(busy_d), 0);

`ifdef SEQ_CHK_COVER_EN
        attempt(4'b0001, 4'b0001, 4'b0001, 1'b0);
        check("cover_pass", 32'(pc_d), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
